// File: rtl/add_cmp_32_if.sv
// Operand/result bundle for the jump/branch add-compare unit.
interface add_cmp_32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       cmp_ctrl;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             cmp_res;
  logic             valid;

  // Requester side: supplies operands, receives results.
  modport master (
    output en, a, b, cmp_ctrl,
    input  sum, cout, ovf, cmp_res, valid
  );

  // Unit side: consumes operands, produces registered results.
  modport slave (
    input  en, a, b, cmp_ctrl,
    output sum, cout, ovf, cmp_res, valid
  );
endinterface

// File: rtl/add_cmp_32.sv
// Registered 32-bit adder and RISC-V branch comparator; one cycle latency.
module add_cmp_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  add_cmp_32_if.slave  bus
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_NE  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_GEU = 3'b110;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             cmp_d, cmp_q;
  logic             valid_q;
  logic             lt_s, lt_u, eq;

  // Adder with carry/overflow flags, carry-in fixed at zero.
  always_comb begin
    sum_d  = '0;
    cout_d = 1'b0;
    {cout_d, sum_d} = {1'b0, bus.a} + {1'b0, bus.b};
    ovf_d  = (bus.a[MSB] == bus.b[MSB]) && (sum_d[MSB] != bus.a[MSB]);
  end

  // Branch condition select; reserved encodings resolve to 0.
  always_comb begin
    eq    = (bus.a == bus.b);
    lt_u  = (bus.a < bus.b);
    lt_s  = ($signed(bus.a) < $signed(bus.b));
    cmp_d = 1'b0;
    unique case (bus.cmp_ctrl)
      CMP_EQ:  cmp_d = eq;
      CMP_NE:  cmp_d = !eq;
      CMP_LT:  cmp_d = lt_s;
      CMP_LTU: cmp_d = lt_u;
      CMP_GE:  cmp_d = !lt_s;
      CMP_GEU: cmp_d = !lt_u;
      default: cmp_d = 1'b0;
    endcase
  end

  // Result register: load on en, otherwise hold; valid tracks en by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cmp_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        cmp_q  <= cmp_d;
      end
    end
  end

  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;
  assign bus.cmp_res = cmp_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_add_cmp_32.sv
// Self-checking bench for add_cmp_32: directed table, corner sequences, random vs model.
module tb_add_cmp_32;

  logic clk;
  logic rst;

  add_cmp_32_if bus ();

  add_cmp_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        cmp;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        cmp;
  } res_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input string tag, input res_t e, input logic exp_valid);
    check({tag, ".sum"},     bus.sum,            e.sum);
    check({tag, ".cout"},    32'(bus.cout),      32'(e.cout));
    check({tag, ".ovf"},     32'(bus.ovf),       32'(e.ovf));
    check({tag, ".cmp_res"}, 32'(bus.cmp_res),   32'(e.cmp));
    check({tag, ".valid"},   32'(bus.valid),     32'(exp_valid));
  endtask

  // Reference: arithmetic on wide integers, comparisons on numeric values.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl);
    res_t r;
    longint ua, ub, sa, sb, us, ss, lim;
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sh0000_0000_8000_0000;
    us  = ua + ub;
    ss  = sa + sb;
    r.sum  = us[31:0];
    r.cout = (us >= 2 * lim);
    r.ovf  = (ss >= lim) || (ss < -lim);
    case (ctrl)
      3'd1:    r.cmp = (ua == ub);
      3'd2:    r.cmp = (ua != ub);
      3'd3:    r.cmp = (sa <  sb);
      3'd4:    r.cmp = (ua <  ub);
      3'd5:    r.cmp = (sa >= sb);
      3'd6:    r.cmp = (ua >= ub);
      default: r.cmp = 1'b0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic en, input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl);
    @(negedge clk);
    bus.en       = en;
    bus.a        = a;
    bus.b        = b;
    bus.cmp_ctrl = ctrl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_t e;
    res_t held;
    logic [31:0] pool [8];
    logic [31:0] ra, rb;
    logic [2:0]  rc;
    logic        ren;

    n_vec = 0;
    n_err = 0;

    vecs[0] = '{32'hFFFF_FFFF, 32'h1, 3'b011, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h1, 3'b100, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h1, 3'b101, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h1, 3'b110, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h7FFF_FFFF, 32'h1, 3'b001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, 3'b001, 32'h2468_ACF0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h1234_5678, 32'h1234_5678, 3'b010, 32'h2468_ACF0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h1234_5678, 32'h1234_5678, 3'b000, 32'h2468_ACF0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h1234_5678, 3'b111, 32'h2468_ACF0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{32'h8000_0000, 32'h8000_0000, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0};

    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0001;
    pool[2] = 32'h7FFF_FFFF; pool[3] = 32'h8000_0000;
    pool[4] = 32'hFFFF_FFFF; pool[5] = 32'h8000_0001;
    pool[6] = 32'h7FFF_FFFE; pool[7] = 32'hFFFF_FFFE;

    // Reset state
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cmp_ctrl = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_res("reset", '{32'h0, 1'b0, 1'b0, 1'b0}, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // PC+4, then hold
    drive(1'b1, 32'h0000_1000, 32'd4, 3'b000);
    check_res("pc4", '{32'h0000_1004, 1'b0, 1'b0, 1'b0}, 1'b1);
    drive(1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 3'b001);
    check_res("pc4_hold", '{32'h0000_1004, 1'b0, 1'b0, 1'b0}, 1'b0);

    // Directed table, applied back-to-back
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ctrl);
      check_res($sformatf("tbl%0d", i), '{vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].cmp}, 1'b1);
    end

    // Back-to-back 10/20/30 + 1
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(10 * i), 32'd1, 3'b001);
      check_res($sformatf("b2b%0d", i), '{32'(10 * i + 1), 1'b0, 1'b0, 1'b0}, 1'b1);
    end
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    check_res("b2b_end", '{32'd31, 1'b0, 1'b0, 1'b0}, 1'b0);

    // Random operands with random en against the model
    held = '{32'd31, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 300; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      rc  = 3'($urandom_range(0, 7));
      ren = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      drive(ren, ra, rb, rc);
      if (ren) held = model(ra, rb, rc);
      check_res($sformatf("rnd%0d", i), held, ren);
    end

    // Asynchronous reset mid-cycle after a valid result
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b110);
    e = model(32'hFFFF_FFFF, 32'h1, 3'b110);
    check_res("pre_arst", e, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_res("arst", '{32'h0, 1'b0, 1'b0, 1'b0}, 1'b0);
    @(posedge clk);
    #1;
    check_res("arst_hold", '{32'h0, 1'b0, 1'b0, 1'b0}, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    bus.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
